// File: rtl/multicycle_ctrl.sv
// Main control FSM for a multi-cycle MIPS datapath.
// Sequences the shared memory port, IR, PC, ALU and register file.
// Traps and halts on an illegal opcode or a memory handshake timeout.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       ext_zero,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       retire,
    output logic       halted,
    output logic [1:0] cause
);

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        R_EXEC,
        R_WB,
        I_EXEC,
        I_WB,
        BRANCH,
        JUMP,
        TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Counter only needs to reach MEM_TIMEOUT-1 before the trap fires.
    localparam int unsigned CW      = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam int unsigned LIMIT_I = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
    localparam logic [CW-1:0] LIMIT = CW'(LIMIT_I);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    cause_q;
    logic          timeout_hit;

    // This waiting cycle is the last one allowed before a timeout trap.
    always_comb begin
        timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == LIMIT);
    end

    // State sequencing, memory wait counter and sticky trap cause.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FETCH;
            wait_cnt <= '0;
            cause_q  <= CAUSE_NONE;
        end else begin
            case (state)
                FETCH, MEM_READ, MEM_WRITE: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        case (state)
                            FETCH:    state <= DECODE;
                            MEM_READ: state <= MEM_WB;
                            default:  state <= FETCH;
                        endcase
                    end else if (timeout_hit) begin
                        wait_cnt <= '0;
                        cause_q  <= CAUSE_TIMEOUT;
                        state    <= TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DECODE: begin
                    wait_cnt <= '0;
                    case (opcode)
                        OP_RTYPE:                state <= R_EXEC;
                        OP_LW, OP_SW:            state <= MEM_ADDR;
                        OP_ADDI, OP_ANDI, OP_ORI: state <= I_EXEC;
                        OP_BEQ:                  state <= BRANCH;
                        OP_J:                    state <= JUMP;
                        default: begin
                            cause_q <= CAUSE_ILLEGAL;
                            state   <= TRAP;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    wait_cnt <= '0;
                    state    <= (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
                end
                R_EXEC:  state <= R_WB;
                I_EXEC:  state <= I_WB;
                MEM_WB, R_WB, I_WB, BRANCH, JUMP: begin
                    wait_cnt <= '0;
                    state    <= FETCH;
                end
                TRAP:    state <= TRAP;
                default: state <= TRAP;
            endcase
        end
    end

    // Datapath controls decoded from the state register; gated by reset_n
    // so every output drops the instant reset asserts, not at the next edge.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        ext_zero   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        halted     = 1'b0;
        cause      = 2'b00;
        if (reset_n) begin
            cause = cause_q;
            case (state)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_READ: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                end
                MEM_WRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                    retire  = mem_ready;
                end
                R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    retire    = 1'b1;
                end
                I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (opcode == OP_ANDI || opcode == OP_ORI) begin
                        alu_op   = 2'b11;
                        ext_zero = 1'b1;
                    end
                end
                I_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_source = 2'b01;
                    pc_write  = zero;
                    retire    = 1'b1;
                end
                JUMP: begin
                    pc_source = 2'b10;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                end
                TRAP: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b1;
                end
            endcase
        end
    end

endmodule
